// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: FSM states, speed
// encodings, framing constants and the byte-wide CRC32 step.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;

  // Reflected CRC32 over one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_frame_checker_if.sv
// Receive sample bus from the PHY capture stage and payload byte stream to
// the RX buffer. slave = frame checker, master = driver/consumer side.
interface eth_rx_frame_checker_if;
  logic [7:0] rxd_i;
  logic       rx_dv_i;
  logic       rx_er_i;
  logic [7:0] data_o;
  logic       v_o;
  logic       last_o;
  logic       error_o;

  modport slave  (input  rxd_i, rx_dv_i, rx_er_i,
                  output data_o, v_o, last_o, error_o);
  modport master (output rxd_i, rx_dv_i, rx_er_i,
                  input  data_o, v_o, last_o, error_o);
endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational next-CRC for one byte; shared with the TX FCS generator.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);

  // one byte step of the reflected CRC32
  always_comb crc_o = crc32_byte(crc_i, byte_i);

endmodule

// File: rtl/eth_rx_frame_checker.sv
// MAC receive framer: strips preamble/SFD and FCS, checks CRC32, length and
// rx_er, and streams payload bytes with last/error marking.
// Optional frame counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_frame_checker
  import eth_pkg::*;
#(
  parameter int unsigned min_frame_p = 64,
  parameter int unsigned max_frame_p = 1518
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 speed_i,
  eth_rx_frame_checker_if.slave      bus,
  output logic [31:0]                stat_good_o,
  output logic [31:0]                stat_crc_err_o,
  output logic [31:0]                stat_runt_o,
  output logic [31:0]                stat_drop_o
);

  localparam logic [10:0] MIN_CNT = 11'(min_frame_p);
  localparam logic [10:0] MAX_CNT = 11'(max_frame_p + 32'd1);

  // registered inputs
  logic [7:0] in_rxd_q;
  logic       in_dv_q, in_dv_prev_q, in_er_q;
  logic [1:0] speed_q;

  // frame state
  rx_state_e       state_q, state_d;
  logic            nib_mode_q, nib_mode_d;
  logic            phase_q, phase_d;
  logic [3:0]      nib_low_q, nib_low_d;
  logic [31:0]     crc_q, crc_d, crc_nxt;
  logic [10:0]     cnt_q, cnt_d, cnt_inc;
  logic            er_seen_q, er_seen_d;
  logic [4:0][7:0] dl_q, dl_d;

  // registered outputs
  logic [7:0] data_q, data_d;
  logic       v_q, v_d, last_q, last_d, error_q, error_d;

  // decode helpers
  rx_state_e  st_eff;
  logic       rise, nib_eff, ph_eff, byte_vld;
  logic [7:0] byte_val;
  logic       end_frame, pre_fail, too_long, long_enough, crc_bad, runt;

  // Input sampling. dv flops reset high so a frame already in flight when
  // reset releases shows no rising edge and is skipped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_rxd_q     <= '0;
      in_dv_q      <= 1'b1;
      in_dv_prev_q <= 1'b1;
      in_er_q      <= 1'b0;
      speed_q      <= '0;
    end else begin
      in_rxd_q     <= bus.rxd_i;
      in_dv_q      <= bus.rx_dv_i;
      in_dv_prev_q <= in_dv_q;
      in_er_q      <= bus.rx_er_i;
      speed_q      <= speed_i;
    end
  end

  // Start detection and byte assembly. On the rising-edge cycle the first
  // sample is already treated as preamble so nibble pairing stays aligned.
  always_comb begin
    rise       = in_dv_q & ~in_dv_prev_q;
    st_eff     = state_q;
    nib_eff    = nib_mode_q;
    ph_eff     = phase_q;
    nib_mode_d = nib_mode_q;
    phase_d    = phase_q;
    nib_low_d  = nib_low_q;
    byte_vld   = 1'b0;
    byte_val   = '0;
    if (state_q == IDLE) begin
      nib_eff    = (speed_q == SPEED_100) || (speed_q == SPEED_10);
      nib_mode_d = nib_eff;
      ph_eff     = 1'b0;
      phase_d    = 1'b0;
      if (rise) st_eff = PRE;
    end
    if (in_dv_q && (st_eff == PRE || st_eff == DATA)) begin
      if (!nib_eff) begin
        byte_vld = 1'b1;
        byte_val = in_rxd_q;
      end else if (!ph_eff) begin
        nib_low_d = in_rxd_q[3:0];
        phase_d   = 1'b1;
      end else begin
        byte_vld = 1'b1;
        byte_val = {in_rxd_q[3:0], nib_low_q};
        phase_d  = 1'b0;
      end
    end
  end

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .byte_i (byte_val),
    .crc_o  (crc_nxt)
  );

  // Frame-level conditions shared by the datapath and the counters.
  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;
    long_enough = cnt_q >= 11'd5;
    crc_bad     = crc_q != ETH_CRC_RESIDUE;
    runt        = cnt_q < MIN_CNT;
    end_frame   = (st_eff == DATA) && !in_dv_q;
    pre_fail    = (st_eff == PRE) && in_dv_q &&
                  (in_er_q || (byte_vld && byte_val != ETH_PREAMBLE &&
                               byte_val != ETH_SFD));
    too_long    = (st_eff == DATA) && in_dv_q && byte_vld && (cnt_inc == MAX_CNT);
  end

  // Next-state, CRC/count update and output beat generation. The oldest
  // delay-line entry leaves once five newer bytes exist, so the FCS never
  // reaches the output.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    er_seen_d = er_seen_q;
    dl_d      = dl_q;
    data_d    = '0;
    v_d       = 1'b0;
    last_d    = 1'b0;
    error_d   = 1'b0;
    case (st_eff)
      PRE: begin
        if (!in_dv_q) begin
          state_d = IDLE;
        end else if (pre_fail) begin
          state_d = DROP;
        end else if (byte_vld && byte_val == ETH_SFD) begin
          state_d   = DATA;
          crc_d     = ETH_CRC_INIT;
          cnt_d     = '0;
          er_seen_d = 1'b0;
        end else begin
          state_d = PRE;
        end
      end
      DATA: begin
        if (end_frame) begin
          state_d = IDLE;
          if (long_enough) begin
            v_d     = 1'b1;
            last_d  = 1'b1;
            data_d  = dl_q[0];
            error_d = crc_bad | er_seen_q | runt | phase_q;
          end
        end else begin
          if (in_er_q) er_seen_d = 1'b1;
          if (byte_vld) begin
            crc_d = crc_nxt;
            cnt_d = cnt_inc;
            dl_d  = {byte_val, dl_q[4:1]};
            if (long_enough) begin
              v_d    = 1'b1;
              data_d = dl_q[0];
            end
            if (too_long) begin
              state_d = DROP;
              last_d  = long_enough;
              error_d = long_enough;
            end
          end
        end
      end
      DROP: begin
        if (!in_dv_q) state_d = IDLE;
      end
      default: ;
    endcase
  end

  // FSM, datapath and registered output flops
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      nib_mode_q <= 1'b0;
      phase_q    <= 1'b0;
      nib_low_q  <= '0;
      crc_q      <= ETH_CRC_INIT;
      cnt_q      <= '0;
      er_seen_q  <= 1'b0;
      dl_q       <= '0;
      data_q     <= '0;
      v_q        <= 1'b0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_mode_q <= nib_mode_d;
      phase_q    <= phase_d;
      nib_low_q  <= nib_low_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      er_seen_q  <= er_seen_d;
      dl_q       <= dl_d;
      data_q     <= data_d;
      v_q        <= v_d;
      last_q     <= last_d;
      error_q    <= error_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.v_o     = v_q;
  assign bus.last_o  = last_q;
  assign bus.error_o = error_q;

`ifdef ETH_RX_STATS_EN
  logic        ev_good_q, ev_good_d, ev_crc_q, ev_crc_d;
  logic        ev_runt_q, ev_runt_d, ev_drop_q, ev_drop_d;
  logic [31:0] good_q, good_d, crc_err_q, crc_err_d;
  logic [31:0] runt_q, runt_d, drop_q, drop_d;

  // Frame-end events are registered, so counters move one cycle after them.
  always_comb begin
    ev_good_d = end_frame && long_enough && !(crc_bad | er_seen_q | runt | phase_q);
    ev_crc_d  = end_frame && long_enough && crc_bad;
    ev_runt_d = end_frame && runt;
    ev_drop_d = pre_fail || too_long || (end_frame && er_seen_q);
    good_d    = good_q    + {31'd0, ev_good_q};
    crc_err_d = crc_err_q + {31'd0, ev_crc_q};
    runt_d    = runt_q    + {31'd0, ev_runt_q};
    drop_d    = drop_q    + {31'd0, ev_drop_q};
  end

  // event and counter flops
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ev_good_q <= 1'b0;
      ev_crc_q  <= 1'b0;
      ev_runt_q <= 1'b0;
      ev_drop_q <= 1'b0;
      good_q    <= '0;
      crc_err_q <= '0;
      runt_q    <= '0;
      drop_q    <= '0;
    end else begin
      ev_good_q <= ev_good_d;
      ev_crc_q  <= ev_crc_d;
      ev_runt_q <= ev_runt_d;
      ev_drop_q <= ev_drop_d;
      good_q    <= good_d;
      crc_err_q <= crc_err_d;
      runt_q    <= runt_d;
      drop_q    <= drop_d;
    end
  end

  assign stat_good_o    = good_q;
  assign stat_crc_err_o = crc_err_q;
  assign stat_runt_o    = runt_q;
  assign stat_drop_o    = drop_q;
`else
  assign stat_good_o    = '0;
  assign stat_crc_err_o = '0;
  assign stat_runt_o    = '0;
  assign stat_drop_o    = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Directed bench for eth_rx_frame_checker with a queue scoreboard.
module tb_eth_rx_frame_checker;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       err;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [1:0]  speed = 2'b10;
  logic [31:0] st_good, st_crc, st_runt, st_drop;

  eth_rx_frame_checker_if bus ();

  eth_rx_frame_checker #(.min_frame_p(64), .max_frame_p(1518)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .speed_i        (speed),
    .bus            (bus),
    .stat_good_o    (st_good),
    .stat_crc_err_o (st_crc),
    .stat_runt_o    (st_runt),
    .stat_drop_o    (st_drop)
  );

  always #4 clk = ~clk;

  beat_t      exp_q[$];
  logic [7:0] frm[$];
  int         total = 0;
  int         bad = 0;
  int unsigned eg = 0, ec = 0, er = 0, ed = 0;

  // monitor: every output beat is matched against the scoreboard head
  always @(negedge clk) begin
    beat_t e;
    if (!reset_i && bus.v_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got d=%h last=%b err=%b", bus.data_o, bus.last_o, bus.error_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_o !== e.d || bus.last_o !== e.last || (e.last && bus.error_o !== e.err)) begin
          bad++;
          $display("FAIL beat got d=%h last=%b err=%b want d=%h last=%b err=%b",
                   bus.data_o, bus.last_o, bus.error_o, e.d, e.last, e.err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    bus.rx_dv_i = dv;
    bus.rxd_i   = d;
    bus.rx_er_i = e;
  endtask

  // preamble + SFD + n bytes 0..n-1 + optional FCS (bit 0 optionally flipped)
  task automatic build_frame(input int n, input bit fcs, input bit flip);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'(i);
      frm.push_back(b);
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB8_8320;
        else             c = c >> 1;
      end
    end
    if (fcs) begin
      c = ~c;
      if (flip) c[0] = ~c[0];
      for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic expect_payload(input int n, input logic err);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d    = 8'(i);
      b.last = (i == n - 1);
      b.err  = err;
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    chk("rst_mid_v", {31'd0, bus.v_o}, 32'd0);
    chk("rst_mid_last", {31'd0, bus.last_o}, 32'd0);
    chk("rst_mid_data", {24'd0, bus.data_o}, 32'd0);
    exp_q.delete();
    eg = 0; ec = 0; er = 0; ed = 0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic send_frame(input bit nib, input int er_at, input int rst_at);
    logic [7:0] b;
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      if (!nib) begin
        cyc(1'b1, b, i == er_at);
      end else begin
        cyc(1'b1, {4'h0, b[3:0]}, i == er_at);
        cyc(1'b1, {4'h0, b[7:4]}, 1'b0);
      end
      if (i == rst_at) do_reset();
    end
    repeat (12) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_stats();
`ifdef ETH_RX_STATS_EN
    chk("stat_good", st_good, eg);
    chk("stat_crc", st_crc, ec);
    chk("stat_runt", st_runt, er);
    chk("stat_drop", st_drop, ed);
`else
    chk("stat_good", st_good, 0);
    chk("stat_crc", st_crc, 0);
    chk("stat_runt", st_runt, 0);
    chk("stat_drop", st_drop, 0);
`endif
  endtask

  initial begin
    bus.rx_dv_i = 1'b0;
    bus.rxd_i   = 8'h00;
    bus.rx_er_i = 1'b0;
    #20;
    chk("reset_v", {31'd0, bus.v_o}, 0);
    chk("reset_data", {24'd0, bus.data_o}, 0);
    chk("reset_last", {31'd0, bus.last_o}, 0);
    chk("reset_error", {31'd0, bus.error_o}, 0);
    check_stats();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    repeat (4) cyc(1'b0, 8'h00, 1'b0);

    // good 64-byte frame, byte mode
    build_frame(60, 1'b1, 1'b0);
    expect_payload(60, 1'b0);
    eg++;
    send_frame(1'b0, -1, -1);
    drain("drain_good");
    check_stats();

    // FCS bit 0 flipped
    build_frame(60, 1'b1, 1'b1);
    expect_payload(60, 1'b1);
    ec++;
    send_frame(1'b0, -1, -1);
    drain("drain_crc");
    check_stats();

    // nibble mode, same frame
    speed = 2'b01;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    build_frame(60, 1'b1, 1'b0);
    expect_payload(60, 1'b0);
    eg++;
    send_frame(1'b1, -1, -1);
    drain("drain_nibble");
    check_stats();
    speed = 2'b10;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);

    // rx_er on payload byte 20
    build_frame(60, 1'b1, 1'b0);
    expect_payload(60, 1'b1);
    ed++;
    send_frame(1'b0, 8 + 20, -1);
    drain("drain_rx_er");
    check_stats();

    // 40-byte runt with valid CRC
    build_frame(36, 1'b1, 1'b0);
    expect_payload(36, 1'b1);
    er++;
    send_frame(1'b0, -1, -1);
    drain("drain_runt40");
    check_stats();

    // 3-byte frame: no beats
    build_frame(3, 1'b0, 1'b0);
    er++;
    send_frame(1'b0, -1, -1);
    drain("drain_runt3");
    check_stats();

    // bad preamble byte: no beats
    build_frame(60, 1'b1, 1'b0);
    frm[3] = 8'h54;
    ed++;
    send_frame(1'b0, -1, -1);
    drain("drain_bad_pre");
    check_stats();

    // reset mid-frame, then a clean frame
    build_frame(60, 1'b1, 1'b0);
    expect_payload(60, 1'b0);
    send_frame(1'b0, -1, 8 + 30);
    drain("drain_reset");
    check_stats();
    build_frame(60, 1'b1, 1'b0);
    expect_payload(60, 1'b0);
    eg++;
    send_frame(1'b0, -1, -1);
    drain("drain_after_reset");
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
